// File: rtl/janus_cube_mmio.sv
// rtl/janus_cube_mmio.sv - Janus cube host MMIO responder: control, MATMUL queue, L0 element writes, status reads
module janus_cube_mmio #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          ARRAY_SIZE = 16,
    parameter int          QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wvalid,
    input  logic [63:0] mem_waddr,
    input  logic [63:0] mem_wdata,
    input  logic [63:0] mem_raddr,
    output logic [63:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_m,
    output logic [15:0] inst_k,
    output logic [15:0] inst_n,
    output logic        start_pulse,
    output logic        soft_rst,
    output logic        l0a_we,
    output logic [5:0]  l0a_entry,
    output logic [3:0]  l0a_row,
    output logic [3:0]  l0a_col,
    output logic [15:0] l0a_wdata,
    output logic        l0b_we,
    output logic [5:0]  l0b_entry,
    output logic [3:0]  l0b_row,
    output logic [3:0]  l0b_col,
    output logic [15:0] l0b_wdata,
    input  logic        core_busy,
    input  logic        core_done,
    output logic        done,
    output logic        busy,
    output logic        queue_full,
    output logic        queue_empty
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] LAST_IDX = 4'(ARRAY_SIZE - 1);

    logic [63:0] woff;
    logic        win;
    logic [15:0] la;
    logic [15:0] lb;
    logic        wr_ctrl, wr_inst, wr_l0a, wr_l0b;
    logic        ctrl_rst, ctrl_start;
    logic        pop, accept;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [47:0] fifo_mem [QDEPTH];
    logic [63:0] mask_a, mask_b;
    logic        ovf;
    logic [63:0] status;
    logic [63:0] rd_next;
    logic        unused_bits;

    assign woff    = mem_waddr - BASE_ADDR;
    assign win     = (mem_waddr >= BASE_ADDR) && (woff < 64'h9000);
    assign la      = woff[15:0] - 16'h1000;
    assign lb      = woff[15:0] - 16'h5000;
    assign wr_ctrl = mem_wvalid && win && (woff == 64'h0);
    assign wr_inst = mem_wvalid && win && (woff == 64'h10);
    assign wr_l0a  = mem_wvalid && win && (woff >= 64'h1000) && (woff < 64'h5000);
    assign wr_l0b  = mem_wvalid && win && (woff >= 64'h5000);

    // RESET dominates START when both bits are written together
    assign ctrl_rst   = wr_ctrl && mem_wdata[1];
    assign ctrl_start = wr_ctrl && mem_wdata[0] && !mem_wdata[1];

    assign inst_valid  = (count != '0);
    assign queue_empty = (count == '0);
    assign queue_full  = (count == CW'(QDEPTH));
    assign busy        = core_busy;
    assign pop         = inst_valid && inst_ready;
    assign accept      = wr_inst && (!queue_full || pop);
    assign {inst_n, inst_k, inst_m} = fifo_mem[rd_ptr];

    assign unused_bits = ^{mem_wdata[63:48], la[15:14], lb[15:14]};

    always_comb begin
        status       = '0;
        status[0]    = done;
        status[1]    = core_busy;
        status[2]    = queue_full;
        status[3]    = queue_empty;
        status[4]    = ovf;
        status[11:8] = 4'(count);
    end

    always_comb begin
        rd_next = '0;
        if (mem_raddr == BASE_ADDR + 64'h8)
            rd_next = status;
        else if (mem_raddr == BASE_ADDR + 64'h18)
            rd_next = mask_a;
        else if (mem_raddr == BASE_ADDR + 64'h20)
            rd_next = mask_b;
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[wr_ptr] <= mem_wdata[47:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            mask_a      <= '0;
            mask_b      <= '0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            start_pulse <= 1'b0;
            soft_rst    <= 1'b0;
            l0a_we      <= 1'b0;
            l0a_entry   <= '0;
            l0a_row     <= '0;
            l0a_col     <= '0;
            l0a_wdata   <= '0;
            l0b_we      <= 1'b0;
            l0b_entry   <= '0;
            l0b_row     <= '0;
            l0b_col     <= '0;
            l0b_wdata   <= '0;
        end else begin
            mem_rdata   <= rd_next;
            start_pulse <= ctrl_start;
            soft_rst    <= ctrl_rst;
            l0a_we      <= wr_l0a;
            l0b_we      <= wr_l0b;
            if (wr_l0a) begin
                l0a_entry <= la[13:8];
                l0a_row   <= la[7:4];
                l0a_col   <= la[3:0];
                l0a_wdata <= mem_wdata[15:0];
            end
            if (wr_l0b) begin
                l0b_entry <= lb[13:8];
                l0b_row   <= lb[7:4];
                l0b_col   <= lb[3:0];
                l0b_wdata <= mem_wdata[15:0];
            end

            if (ctrl_rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                mask_a <= '0;
                mask_b <= '0;
                ovf    <= 1'b0;
                done   <= 1'b0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (accept)
                    wr_ptr <= wr_ptr + 1'b1;
                count <= count + CW'(accept) - CW'(pop);
                if (wr_inst && !accept)
                    ovf <= 1'b1;
                // An entry is complete once its last element lands
                if (wr_l0a && la[7:4] == LAST_IDX && la[3:0] == LAST_IDX)
                    mask_a[la[13:8]] <= 1'b1;
                if (wr_l0b && lb[7:4] == LAST_IDX && lb[3:0] == LAST_IDX)
                    mask_b[lb[13:8]] <= 1'b1;
                if (ctrl_start)
                    done <= 1'b0;
                else if (core_done)
                    done <= 1'b1;
            end
        end
    end
endmodule
